// File: rtl/fnd_scan_periph_if.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_periph_if
//  Description : APB3-style bus bundle between a bus master and the
//                fnd_scan_periph display controller.
//                master modport : drives PADDR/PWDATA/PWRITE/PENABLE/PSEL,
//                                 receives PRDATA/PREADY
//                slave modport  : the reverse
//  Revision    : 1.0  initial release
// ============================================================================
interface fnd_scan_periph_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE;
    logic              PENABLE;
    logic              PSEL;
    logic [31:0]       PRDATA;
    logic              PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface
`default_nettype wire

// File: rtl/fnd_scan_periph.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_periph
//  Description : APB slave driving an N-digit multiplexed 7-segment display.
//                Software loads digit nibbles, dp mask, digit-enable mask and
//                blink settings once; the block scans the digits itself.
//  Ports       : PCLK     - system clock
//                PRESET   - asynchronous active-low reset
//                apb      - APB slave bundle (fnd_scan_periph_if.slave)
//                fndcomm  - digit commons, active-low, one per digit
//                fndfont  - segments {dp,g..a}, active-low
//  Registers   : 0x00 FCR [0] EN, [1] BLINK_EN
//                0x04 FMR digit enable mask
//                0x08 FDR 4-bit hex value per digit
//                0x0C FPR decimal-point mask
//                0x10 FBR [15:0] blink half-period in scan frames
//                0x14 FSR (RO) [2:0] digit index, [8] blink phase
//  Revision    : 1.0  initial release
// ============================================================================
module fnd_scan_periph #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int ADDR_W     = 5
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    fnd_scan_periph_if.slave      apb,
    output logic [NUM_DIGITS-1:0] fndcomm,
    output logic [7:0]            fndfont
);

    // ------------------------------------------------------------------
    // Derived widths and register word offsets
    // ------------------------------------------------------------------
    localparam int c_PW = $clog2(SCAN_DIV);
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_WW = ADDR_W - 2;

    localparam logic [c_WW-1:0] c_A_FCR = c_WW'(0);
    localparam logic [c_WW-1:0] c_A_FMR = c_WW'(1);
    localparam logic [c_WW-1:0] c_A_FDR = c_WW'(2);
    localparam logic [c_WW-1:0] c_A_FPR = c_WW'(3);
    localparam logic [c_WW-1:0] c_A_FBR = c_WW'(4);
    localparam logic [c_WW-1:0] c_A_FSR = c_WW'(5);

    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(SCAN_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                      r_en;
    logic                      r_blink_en;
    logic [NUM_DIGITS-1:0]     r_fmr;
    logic [4*NUM_DIGITS-1:0]   r_fdr;
    logic [NUM_DIGITS-1:0]     r_fpr;
    logic [15:0]               r_fbr;

    logic [c_PW-1:0]           r_presc;
    logic [c_IW-1:0]           r_idx;
    logic [15:0]               r_frame;
    logic                      r_phase;

    logic                      r_pready;
    logic [31:0]               r_prdata;

    // ------------------------------------------------------------------
    // APB decode. The !PREADY term makes the access phase last exactly one
    // cycle before PREADY answers, giving a single wait state.
    // ------------------------------------------------------------------
    logic            w_access;
    logic            w_wr;
    logic            w_rd;
    logic [c_WW-1:0] w_word;
    logic            w_wr_fcr;
    logic            w_wr_fmr;
    logic            w_wr_fdr;
    logic            w_wr_fpr;
    logic            w_wr_fbr;
    logic [31:0]     w_rdata;
    logic            w_unused;

    assign w_access = apb.PSEL & apb.PENABLE & ~r_pready;
    assign w_wr     = w_access &  apb.PWRITE;
    assign w_rd     = w_access & ~apb.PWRITE;
    assign w_word   = apb.PADDR[ADDR_W-1:2];

    assign w_wr_fcr = w_wr & (w_word == c_A_FCR);
    assign w_wr_fmr = w_wr & (w_word == c_A_FMR);
    assign w_wr_fdr = w_wr & (w_word == c_A_FDR);
    assign w_wr_fpr = w_wr & (w_word == c_A_FPR);
    assign w_wr_fbr = w_wr & (w_word == c_A_FBR);

    // Byte-lane bits and unimplemented data bits are intentionally ignored.
    assign w_unused = ^{apb.PADDR[1:0], apb.PWDATA};

    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_A_FCR: w_rdata = {30'd0, r_blink_en, r_en};
            c_A_FMR: w_rdata = 32'(r_fmr);
            c_A_FDR: w_rdata = 32'(r_fdr);
            c_A_FPR: w_rdata = 32'(r_fpr);
            c_A_FBR: w_rdata = {16'd0, r_fbr};
            c_A_FSR: w_rdata = {23'd0, r_phase, 5'd0, 3'(r_idx)};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_pready <= 1'b0;
            r_prdata <= '0;
        end else begin
            r_pready <= w_access;
            r_prdata <= w_rd ? w_rdata : '0;
        end
    end

    assign apb.PREADY = r_pready;
    assign apb.PRDATA = r_prdata;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_en       <= 1'b0;
            r_blink_en <= 1'b0;
            r_fmr      <= '0;
            r_fdr      <= '0;
            r_fpr      <= '0;
            r_fbr      <= '0;
        end else begin
            if (w_wr_fcr) begin
                r_en       <= apb.PWDATA[0];
                r_blink_en <= apb.PWDATA[1];
            end
            if (w_wr_fmr) r_fmr <= apb.PWDATA[NUM_DIGITS-1:0];
            if (w_wr_fdr) r_fdr <= apb.PWDATA[4*NUM_DIGITS-1:0];
            if (w_wr_fpr) r_fpr <= apb.PWDATA[NUM_DIGITS-1:0];
            if (w_wr_fbr) r_fbr <= apb.PWDATA[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Scan engine: prescaler -> digit index -> frame counter -> blink phase
    // ------------------------------------------------------------------
    logic w_presc_tc;
    logic w_idx_tc;
    logic w_frame_end;
    logic w_scan_clr;

    assign w_presc_tc  = (r_presc == c_PRESC_LAST);
    assign w_idx_tc    = (r_idx == c_IDX_LAST);
    assign w_frame_end = w_presc_tc & w_idx_tc;
    // Clearing EN zeroes the counters on the same edge that drops r_en, so
    // FSR reads back index 0 as soon as the write completes.
    assign w_scan_clr  = ~r_en | (w_wr_fcr & ~apb.PWDATA[0]);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_scan_clr) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_presc_tc) begin
            r_presc <= '0;
            r_idx   <= w_idx_tc ? '0 : r_idx + c_IW'(1);
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (w_scan_clr || w_wr_fbr) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (r_fbr == 16'd0) begin
                r_frame <= '0;
                r_phase <= 1'b0;
            end else if (r_frame == r_fbr - 16'd1) begin
                r_frame <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frame <= r_frame + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage. Built from the current register values, so the pins
    // follow any index change or register write one cycle later.
    // A masked digit keeps its slot and simply stays dark.
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_seg(input logic [3:0] i_val);
        logic [6:0] w_seg;
        case (i_val)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
        return w_seg;
    endfunction

    logic [3:0]            w_nib;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_comm;

    assign w_nib  = r_fdr[{r_idx, 2'b00} +: 4];
    assign w_lit  = r_en & r_fmr[r_idx] & ~(r_blink_en & r_phase);
    assign w_comm = ~(NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            fndcomm <= '1;
            fndfont <= 8'hFF;
        end else if (w_lit) begin
            fndcomm <= w_comm;
            fndfont <= {~r_fpr[r_idx], f_seg(w_nib)};
        end else begin
            fndcomm <= '1;
            fndfont <= 8'hFF;
        end
    end

endmodule
`default_nettype wire
